// File: rtl/demux_1to2_8bits_stream.sv
// Registered 1-to-2 stream demultiplexer: each accepted input word is routed by IN_SEL
// into one of two per-output FIFOs with valid/ready handshakes on every side.

module demux_1to2_8bits_stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned LVLW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]  level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop;

    always_comb begin
        pop      = (level_q != '0) && pop_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVLW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVLW'(1);
        end

        // Head is a register: the new head is either the word being written now
        // (FIFO effectively empty after the pop) or an already stored entry.
        // With nothing left, the last head value is held.
        if (level_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign out_data  = head_q;
    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign full      = (level_q == LVLW'(DEPTH));

endmodule

module demux_1to2_8bits_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           IN_DATA,
    input  logic                       IN_SEL,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic [WIDTH-1:0]           OUT1_DATA,
    output logic                       OUT1_VALID,
    input  logic                       OUT1_READY,
    output logic [WIDTH-1:0]           OUT2_DATA,
    output logic                       OUT2_VALID,
    input  logic                       OUT2_READY,
    output logic [$clog2(DEPTH+1)-1:0] OUT1_LEVEL,
    output logic [$clog2(DEPTH+1)-1:0] OUT2_LEVEL
);
    logic full1, full2;
    logic push1, push2;

    // Ready depends only on the select and registered full flags, never on OUTn_READY.
    always_comb begin
        IN_READY = !RST && !(IN_SEL ? full2 : full1);
        push1    = IN_VALID && IN_READY && !IN_SEL;
        push2    = IN_VALID && IN_READY &&  IN_SEL;
    end

    demux_1to2_8bits_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (CLK),
        .rst       (RST),
        .push      (push1),
        .push_data (IN_DATA),
        .pop_ready (OUT1_READY),
        .out_data  (OUT1_DATA),
        .out_valid (OUT1_VALID),
        .level     (OUT1_LEVEL),
        .full      (full1)
    );

    demux_1to2_8bits_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk       (CLK),
        .rst       (RST),
        .push      (push2),
        .push_data (IN_DATA),
        .pop_ready (OUT2_READY),
        .out_data  (OUT2_DATA),
        .out_valid (OUT2_VALID),
        .level     (OUT2_LEVEL),
        .full      (full2)
    );

endmodule

// File: tb/tb_demux_1to2_8bits_stream.sv
// Scoreboard bench for demux_1to2_8bits_stream: driver queues expected words on accept,
// monitor checks level/valid every cycle and data on every pop.

module tb_demux_1to2_8bits_stream;
    logic       CLK;
    logic       RST;
    logic [7:0] IN_DATA;
    logic       IN_SEL;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] OUT1_DATA;
    logic       OUT1_VALID;
    logic       OUT1_READY;
    logic [7:0] OUT2_DATA;
    logic       OUT2_VALID;
    logic       OUT2_READY;
    logic [1:0] OUT1_LEVEL;
    logic [1:0] OUT2_LEVEL;

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    demux_1to2_8bits_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_DATA    (IN_DATA),
        .IN_SEL     (IN_SEL),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT1_DATA  (OUT1_DATA),
        .OUT1_VALID (OUT1_VALID),
        .OUT1_READY (OUT1_READY),
        .OUT2_DATA  (OUT2_DATA),
        .OUT2_VALID (OUT2_VALID),
        .OUT2_READY (OUT2_READY),
        .OUT1_LEVEL (OUT1_LEVEL),
        .OUT2_LEVEL (OUT2_LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: negedge+1 checks occupancy, negedge+3 checks the word about to be popped.
    always begin
        @(negedge CLK);
        #1;
        chk("lvl1", OUT1_LEVEL, q1.size());
        chk("lvl2", OUT2_LEVEL, q2.size());
        chk("vld1", OUT1_VALID, (q1.size() != 0) ? 1 : 0);
        chk("vld2", OUT2_VALID, (q2.size() != 0) ? 1 : 0);
        #2;
        if (OUT1_VALID && OUT1_READY && q1.size() != 0) chk("data1", OUT1_DATA, q1.pop_front());
        if (OUT2_VALID && OUT2_READY && q2.size() != 0) chk("data2", OUT2_DATA, q2.pop_front());
    end

    // Driver: apply at negedge, sample IN_READY at negedge+2 (before the accepting edge).
    task automatic send(input logic [7:0] d, input logic s);
        int unsigned budget = 20;
        @(negedge CLK);
        IN_DATA  = d;
        IN_SEL   = s;
        IN_VALID = 1'b1;
        #2;
        while (!IN_READY && budget != 0) begin
            budget--;
            @(negedge CLK);
            #2;
        end
        if (!IN_READY) begin
            chk("send_timeout", 0, 1);
            IN_VALID = 1'b0;
        end else if (s) q2.push_back(d);
        else            q1.push_back(d);
    endtask

    task automatic idle(input int unsigned n);
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST        = 1'b1;
        IN_DATA    = '0;
        IN_SEL     = 1'b0;
        IN_VALID   = 1'b0;
        OUT1_READY = 1'b0;
        OUT2_READY = 1'b0;
        #13;
        chk("rst_ready", IN_READY, 0);
        chk("rst_data1", OUT1_DATA, 0);
        chk("rst_data2", OUT2_DATA, 0);
        #10 RST = 1'b0;
        idle(1);

        // 1: reset with FIFO1 holding two words
        send(8'd11, 1'b0);
        send(8'd22, 1'b0);
        @(posedge CLK);
        #2;
        chk("pre_rst_lvl1", OUT1_LEVEL, 2);
        #1;
        RST      = 1'b1;
        IN_VALID = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        chk("rst_mid_vld1", OUT1_VALID, 0);
        chk("rst_mid_lvl1", OUT1_LEVEL, 0);
        chk("rst_mid_ready", IN_READY, 0);
        @(posedge CLK);
        #3 RST = 1'b0;
        OUT1_READY = 1'b1;
        OUT2_READY = 1'b1;
        idle(3);

        // 2: routing
        send(8'd1, 1'b0);
        send(8'd3, 1'b1);
        idle(3);
        chk("route_d1", OUT1_DATA, 1);
        chk("route_d2", OUT2_DATA, 3);

        // 3/4: order, full, head-of-line
        OUT1_READY = 1'b0;
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        @(negedge CLK);
        IN_DATA  = 8'hBB;
        IN_SEL   = 1'b0;
        IN_VALID = 1'b1;
        #2;
        chk("full_ready", IN_READY, 0);
        chk("full_lvl1", OUT1_LEVEL, 2);
        @(negedge CLK);
        #2;
        chk("hol_ready", IN_READY, 0);
        chk("hol_lvl2", OUT2_LEVEL, 0);
        send(8'hBB, 1'b1);
        @(negedge CLK);
        IN_VALID   = 1'b0;
        IN_SEL     = 1'b0;
        OUT1_READY = 1'b1;
        @(negedge CLK);
        #2;
        chk("after_pop_ready", IN_READY, 1);
        idle(3);

        // 5: streaming 0..19 on OUT1
        for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
        idle(3);
        chk("stream_last", OUT1_DATA, 19);

        // 6: random traffic
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            IN_VALID   = 1'($urandom_range(0, 1));
            IN_SEL     = 1'($urandom_range(0, 1));
            IN_DATA    = 8'($urandom);
            OUT1_READY = 1'($urandom_range(0, 1));
            OUT2_READY = 1'($urandom_range(0, 1));
            #2;
            chk("rnd_ready", IN_READY, ((IN_SEL ? q2.size() : q1.size()) < 2) ? 1 : 0);
            if (IN_VALID && IN_READY) begin
                if (IN_SEL) q2.push_back(IN_DATA);
                else        q1.push_back(IN_DATA);
            end
        end
        @(negedge CLK);
        IN_VALID   = 1'b0;
        OUT1_READY = 1'b1;
        OUT2_READY = 1'b1;
        for (int i = 0; i < 10 && (q1.size() + q2.size()) != 0; i++) @(negedge CLK);
        @(negedge CLK);
        chk("drain", q1.size() + q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
